// File: rtl/sub_digit_serial.sv
// Digit-serial subtractor: diff = a - b - b_in, one DIGIT-wide slice per clock, LSB first.
// Optional two's-complement overflow output enabled by defining SUB_DIGIT_SERIAL_OVF_EN.
module sub_digit_serial #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             b_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             b_out
`ifdef SUB_DIGIT_SERIAL_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned NDIG = WIDTH / DIGIT;
   localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic               borrow_q, borrow_d;
   logic               in_ready_q, in_ready_d;
   logic               out_valid_q, out_valid_d;
   logic [WIDTH-1:0]   diff_q, diff_d;
   logic               b_out_q, b_out_d;
   logic               ovf_q, ovf_d;

   logic [DIGIT-1:0]   a_k_c, b_k_c;
   logic [DIGIT:0]     sum_c;

   // Next-state and datapath: one slice per RUN cycle, borrow carried in a flop.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      a_d         = a_q;
      b_d         = b_q;
      borrow_d    = borrow_q;
      diff_d      = diff_q;
      b_out_d     = b_out_q;
      ovf_d       = ovf_q;
      a_k_c       = '0;
      b_k_c       = '0;

      for (int k = 0; k < int'(NDIG); k++) begin
         if (cnt_q == CW'(k)) begin
            a_k_c = a_q[k*DIGIT +: DIGIT];
            b_k_c = b_q[k*DIGIT +: DIGIT];
         end
      end
      sum_c = {1'b0, a_k_c} + {1'b0, ~b_k_c} + {{DIGIT{1'b0}}, ~borrow_q};

      case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               a_d      = a;
               b_d      = b;
               borrow_d = b_in;
               cnt_d    = '0;
               state_d  = RUN;
            end
         end
         RUN: begin
            for (int k = 0; k < int'(NDIG); k++) begin
               if (cnt_q == CW'(k)) diff_d[k*DIGIT +: DIGIT] = sum_c[DIGIT-1:0];
            end
            borrow_d = ~sum_c[DIGIT];
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CW'(NDIG - 1)) begin
               b_out_d = ~sum_c[DIGIT];
               // Result MSB comes from the top slice being written this cycle.
               ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sum_c[DIGIT-1] != a_q[WIDTH-1]);
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         borrow_q    <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         diff_q      <= '0;
         b_out_q     <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         a_q         <= a_d;
         b_q         <= b_d;
         borrow_q    <= borrow_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         diff_q      <= diff_d;
         b_out_q     <= b_out_d;
         ovf_q       <= ovf_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign diff      = diff_q;
   assign b_out     = b_out_q;

`ifdef SUB_DIGIT_SERIAL_OVF_EN
   assign ovf = ovf_q;
`else
   logic unused_ovf;
   assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_sub_digit_serial.sv
// Scoreboard bench for sub_digit_serial: driver queues hand-computed results, monitor checks transfers.
module tb_sub_digit_serial;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic        bin;
      logic [15:0] d;
      logic        bo;
      logic        ov;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        b_in;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] diff;
   logic        b_out;
`ifdef SUB_DIGIT_SERIAL_OVF_EN
   logic        ovf;
`endif

   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;
   logic ov_prev = 1'b0;
   vec_t exp_q[$];
   int   acc_q[$];

   sub_digit_serial #(.WIDTH(16), .DIGIT(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .b_in      (b_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .b_out     (b_out)
`ifdef SUB_DIGIT_SERIAL_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic [15:0] va, input logic [15:0] vb, input logic vbin,
                               input logic [15:0] vd, input logic vbo, input logic vov);
      vec_t v;
      v.a = va; v.b = vb; v.bin = vbin; v.d = vd; v.bo = vbo; v.ov = vov;
      return v;
   endfunction

   // Monitor: latency on out_valid rise, result compare on each transfer.
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid && !ov_prev) begin
            if (acc_q.size() == 0) chk("spurious_out_valid", 1, 0);
            else chk("latency", 32'(cyc - acc_q.pop_front()), 4);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
            else begin
               vec_t e;
               e = exp_q.pop_front();
               chk("diff", 32'(diff), 32'(e.d));
               chk("b_out", 32'(b_out), 32'(e.bo));
`ifdef SUB_DIGIT_SERIAL_OVF_EN
               chk("ovf", 32'(ovf), 32'(e.ov));
`endif
            end
         end
      end
      ov_prev = out_valid;
   end

   // Enter at posedge+1; waits for in_ready, presents for one accepting edge.
   task automatic send(input vec_t v);
      int n = 0;
      while (in_ready !== 1'b1 && n < 200) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 200) chk("in_ready_timeout", 0, 1);
      a = v.a; b = v.b; b_in = v.bin; in_valid = 1'b1;
      exp_q.push_back(v);
      @(posedge clk); #1;
      in_valid = 1'b0;
      acc_q.push_back(cyc);
   endtask

   task automatic wait_valid();
      int n = 0;
      while (out_valid !== 1'b1 && n < 50) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 50) chk("out_valid_timeout", 0, 1);
   endtask

   initial begin
      vec_t tbl[$];
      int   n;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; b_in = 1'b0;
      #12;
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_diff", 32'(diff), 0);
      chk("rst_b_out", 32'(b_out), 0);
      @(posedge clk); #1; rst_n = 1'b1;
      @(posedge clk); #1;

      send(mk(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0));
      send(mk(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0));
      send(mk(16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0));
      send(mk(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1));
      wait_valid();
      @(posedge clk); #1;

      // Backpressure: result held, new operands refused.
      out_ready = 1'b0;
      send(mk(16'h00A0, 16'h0050, 1'b0, 16'h0050, 1'b0, 1'b0));
      wait_valid();
      a = 16'hDEAD; b = 16'h0001; b_in = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("hold_out_valid", 32'(out_valid), 1);
         chk("hold_diff", 32'(diff), 32'h0050);
         chk("hold_b_out", 32'(b_out), 0);
         chk("hold_in_ready", 32'(in_ready), 0);
      end
      out_ready = 1'b1; in_valid = 1'b0;
      @(posedge clk); #1;
      chk("post_xfer_out_valid", 32'(out_valid), 0);
      chk("post_xfer_in_ready", 32'(in_ready), 1);
      @(posedge clk); #1;
      chk("no_second_op", 32'(out_valid), 0);
      chk("hold_queue_empty", 32'(exp_q.size()), 0);

      // Reset two edges into RUN aborts the operation.
      send(mk(16'h1111, 16'h0001, 1'b0, 16'h1110, 1'b0, 1'b0));
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("abort_out_valid", 32'(out_valid), 0);
      chk("abort_diff", 32'(diff), 0);
      chk("abort_in_ready", 32'(in_ready), 1);
      chk("abort_b_out", 32'(b_out), 0);
      exp_q.delete();
      acc_q.delete();
      @(posedge clk); #1; rst_n = 1'b1;
      @(posedge clk); #1;
      send(mk(16'h00FF, 16'h000F, 1'b0, 16'h00F0, 1'b0, 1'b0));

      // Back-to-back extremes and mixed classes.
      tbl.push_back(mk(16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b0));
      tbl.push_back(mk(16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0));
      tbl.push_back(mk(16'h0000, 16'hFFFF, 1'b0, 16'h0001, 1'b1, 1'b0));
      tbl.push_back(mk(16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0));
      tbl.push_back(mk(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1));
      tbl.push_back(mk(16'h8000, 16'h7FFF, 1'b0, 16'h0001, 1'b0, 1'b1));
      tbl.push_back(mk(16'hABCD, 16'h1234, 1'b1, 16'h9998, 1'b0, 1'b0));
      tbl.push_back(mk(16'h1234, 16'hABCD, 1'b0, 16'h6667, 1'b1, 1'b0));
      tbl.push_back(mk(16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b0));
      tbl.push_back(mk(16'h0001, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0));
      foreach (tbl[i]) send(tbl[i]);

      n = 0;
      while ((exp_q.size() != 0 || out_valid === 1'b1) && n < 100) begin
         @(posedge clk); #1; n++;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("final_queue_empty", 32'(exp_q.size()), 0);
      chk("final_out_valid", 32'(out_valid), 0);
      chk("final_in_ready", 32'(in_ready), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
